// File: rtl/layer_data_ram_controller.sv
// ---------------------------------------------------------------------------
// layer_data_ram_controller
//
// Sole initiator of the layer-data block RAM. It sits between the neuron
// datapath and the RAM and serialises every access:
//   - Write side: after i_wr_start, each i_wr_valid beat becomes one RAM write
//     to the next sequential node address of the latched layer.
//   - Read side: after i_rd_start, requests every node of the latched layer on
//     consecutive cycles and forwards the returned data as a stream. The final
//     node carries o_rd_last and o_rd_done.
//
// Ports:
//   clk, rst                  clock (rising edge), async active-high reset
//   i_wr_start / i_wr_layer   start a layer write, target layer
//   i_wr_valid / i_wr_data    node value stream to be written
//   i_rd_start / i_rd_layer   start a layer read, source layer
//   o_busy                    controller not idle
//   o_wr_done                 pulse with the final write request
//   o_rd_valid/addr/data      forwarded read stream
//   o_rd_last, o_rd_done      mark the final node of the read
//   o_ram_*                   RAM request (enable, rw_select 1=read, layer, addr, data)
//   i_ram_*                   RAM read response (1-cycle latency)
//
// Every output is a register.
// ---------------------------------------------------------------------------
module layer_data_ram_controller #(
    parameter int DATA_WIDTH                    = 32,
    parameter int LAYER_WIDTH                   = 2,
    parameter int NUMBER_OF_INPUT_NODE          = 2,
    parameter int NUMBER_OF_HIDDEN_NODE_LAYER_1 = 32,
    parameter int NUMBER_OF_HIDDEN_NODE_LAYER_2 = 32,
    parameter int NUMBER_OF_OUTPUT_NODE         = 3,
    localparam int ADDR_WIDTH = $clog2(NUMBER_OF_HIDDEN_NODE_LAYER_1)
) (
    input  logic                   clk,
    input  logic                   rst,

    input  logic                   i_wr_start,
    input  logic [LAYER_WIDTH-1:0] i_wr_layer,
    input  logic                   i_wr_valid,
    input  logic [DATA_WIDTH-1:0]  i_wr_data,

    input  logic                   i_rd_start,
    input  logic [LAYER_WIDTH-1:0] i_rd_layer,

    output logic                   o_busy,
    output logic                   o_wr_done,
    output logic                   o_rd_valid,
    output logic [ADDR_WIDTH-1:0]  o_rd_addr,
    output logic [DATA_WIDTH-1:0]  o_rd_data,
    output logic                   o_rd_last,
    output logic                   o_rd_done,

    output logic                   o_ram_enable,
    output logic                   o_ram_rw_select,
    output logic [LAYER_WIDTH-1:0] o_ram_layer,
    output logic [ADDR_WIDTH-1:0]  o_ram_addr,
    output logic [DATA_WIDTH-1:0]  o_ram_data,

    input  logic                   i_ram_valid,
    input  logic [LAYER_WIDTH-1:0] i_ram_layer,
    input  logic [ADDR_WIDTH-1:0]  i_ram_addr,
    input  logic [DATA_WIDTH-1:0]  i_ram_data
);

    typedef enum logic [1:0] {
        StIdle,
        StWrite,
        StReadIssue,
        StReadWait
    } state_e;

    state_e                 state_q;
    logic [LAYER_WIDTH-1:0] layer_q;
    logic [ADDR_WIDTH-1:0]  wr_cnt_q;   // address of the next write
    logic [ADDR_WIDTH-1:0]  rd_cnt_q;   // address of the next read request
    logic [ADDR_WIDTH-1:0]  last_addr;  // N-1 of the latched layer
    logic                   rsp_accept;

    // Highest node address of a layer (node count minus one).
    function automatic logic [ADDR_WIDTH-1:0] layer_last_addr(
        input logic [LAYER_WIDTH-1:0] layer
    );
        logic [ADDR_WIDTH-1:0] result;
        case (layer)
            LAYER_WIDTH'(0): result = ADDR_WIDTH'(NUMBER_OF_INPUT_NODE - 1);
            LAYER_WIDTH'(1): result = ADDR_WIDTH'(NUMBER_OF_HIDDEN_NODE_LAYER_1 - 1);
            LAYER_WIDTH'(2): result = ADDR_WIDTH'(NUMBER_OF_HIDDEN_NODE_LAYER_2 - 1);
            default:         result = ADDR_WIDTH'(NUMBER_OF_OUTPUT_NODE - 1);
        endcase
        return result;
    endfunction

    always_comb begin
        last_addr  = layer_last_addr(layer_q);
        // Only responses for the layer being read, and only while a read is
        // in flight, are forwarded; everything else is dropped silently.
        rsp_accept = ((state_q == StReadIssue) || (state_q == StReadWait)) &&
                     i_ram_valid && (i_ram_layer == layer_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= StIdle;
            layer_q         <= '0;
            wr_cnt_q        <= '0;
            rd_cnt_q        <= '0;
            o_busy          <= 1'b0;
            o_wr_done       <= 1'b0;
            o_rd_valid      <= 1'b0;
            o_rd_addr       <= '0;
            o_rd_data       <= '0;
            o_rd_last       <= 1'b0;
            o_rd_done       <= 1'b0;
            o_ram_enable    <= 1'b0;
            o_ram_rw_select <= 1'b0;
            o_ram_layer     <= '0;
            o_ram_addr      <= '0;
            o_ram_data      <= '0;
        end else begin
            // Pulse-style outputs default low every cycle.
            o_wr_done    <= 1'b0;
            o_rd_valid   <= 1'b0;
            o_rd_last    <= 1'b0;
            o_rd_done    <= 1'b0;
            o_ram_enable <= 1'b0;

            case (state_q)
                StIdle: begin
                    // Write has priority; a simultaneous read start is lost.
                    if (i_wr_start) begin
                        state_q  <= StWrite;
                        layer_q  <= i_wr_layer;
                        wr_cnt_q <= '0;
                        o_busy   <= 1'b1;
                    end else if (i_rd_start) begin
                        // Address 0 goes out straight away so the request
                        // lands in the cycle after the start pulse.
                        layer_q         <= i_rd_layer;
                        o_busy          <= 1'b1;
                        o_ram_enable    <= 1'b1;
                        o_ram_rw_select <= 1'b1;
                        o_ram_layer     <= i_rd_layer;
                        o_ram_addr      <= '0;
                        o_ram_data      <= '0;
                        if (layer_last_addr(i_rd_layer) == '0) begin
                            rd_cnt_q <= '0;
                            state_q  <= StReadWait;
                        end else begin
                            rd_cnt_q <= ADDR_WIDTH'(1);
                            state_q  <= StReadIssue;
                        end
                    end
                end

                StWrite: begin
                    if (i_wr_valid) begin
                        o_ram_enable    <= 1'b1;
                        o_ram_rw_select <= 1'b0;
                        o_ram_layer     <= layer_q;
                        o_ram_addr      <= wr_cnt_q;
                        o_ram_data      <= i_wr_data;
                        if (wr_cnt_q == last_addr) begin
                            o_wr_done <= 1'b1;
                            o_busy    <= 1'b0;
                            state_q   <= StIdle;
                        end else begin
                            wr_cnt_q <= wr_cnt_q + ADDR_WIDTH'(1);
                        end
                    end
                end

                StReadIssue: begin
                    o_ram_enable    <= 1'b1;
                    o_ram_rw_select <= 1'b1;
                    o_ram_layer     <= layer_q;
                    o_ram_addr      <= rd_cnt_q;
                    o_ram_data      <= '0;
                    // Counter parks at N-1; it never wraps.
                    if (rd_cnt_q == last_addr) begin
                        state_q <= StReadWait;
                    end else begin
                        rd_cnt_q <= rd_cnt_q + ADDR_WIDTH'(1);
                    end
                end

                StReadWait: begin
                    // All requests issued; only responses matter here.
                end

                default: begin
                    state_q <= StIdle;
                    o_busy  <= 1'b0;
                end
            endcase

            // Response forwarding overrides the state update above when the
            // final node comes back, ending the read in the same cycle.
            if (rsp_accept) begin
                o_rd_valid <= 1'b1;
                o_rd_addr  <= i_ram_addr;
                o_rd_data  <= i_ram_data;
                if (i_ram_addr == last_addr) begin
                    o_rd_last    <= 1'b1;
                    o_rd_done    <= 1'b1;
                    o_busy       <= 1'b0;
                    o_ram_enable <= 1'b0;
                    state_q      <= StIdle;
                end
            end
        end
    end

endmodule

// File: tb/tb_layer_data_ram_controller.sv
// Testbench for layer_data_ram_controller: a behavioural 1-cycle-latency RAM
// answers the controller; cycle tables plus hand-written sequences check it.
module tb_layer_data_ram_controller;

    logic        clk;
    logic        rst;
    logic        i_wr_start;
    logic [1:0]  i_wr_layer;
    logic        i_wr_valid;
    logic [31:0] i_wr_data;
    logic        i_rd_start;
    logic [1:0]  i_rd_layer;
    logic        o_busy;
    logic        o_wr_done;
    logic        o_rd_valid;
    logic [4:0]  o_rd_addr;
    logic [31:0] o_rd_data;
    logic        o_rd_last;
    logic        o_rd_done;
    logic        o_ram_enable;
    logic        o_ram_rw_select;
    logic [1:0]  o_ram_layer;
    logic [4:0]  o_ram_addr;
    logic [31:0] o_ram_data;
    logic        i_ram_valid;
    logic [1:0]  i_ram_layer;
    logic [4:0]  i_ram_addr;
    logic [31:0] i_ram_data;

    layer_data_ram_controller dut (
        .clk             (clk),
        .rst             (rst),
        .i_wr_start      (i_wr_start),
        .i_wr_layer      (i_wr_layer),
        .i_wr_valid      (i_wr_valid),
        .i_wr_data       (i_wr_data),
        .i_rd_start      (i_rd_start),
        .i_rd_layer      (i_rd_layer),
        .o_busy          (o_busy),
        .o_wr_done       (o_wr_done),
        .o_rd_valid      (o_rd_valid),
        .o_rd_addr       (o_rd_addr),
        .o_rd_data       (o_rd_data),
        .o_rd_last       (o_rd_last),
        .o_rd_done       (o_rd_done),
        .o_ram_enable    (o_ram_enable),
        .o_ram_rw_select (o_ram_rw_select),
        .o_ram_layer     (o_ram_layer),
        .o_ram_addr      (o_ram_addr),
        .o_ram_data      (o_ram_data),
        .i_ram_valid     (i_ram_valid),
        .i_ram_layer     (i_ram_layer),
        .i_ram_addr      (i_ram_addr),
        .i_ram_data      (i_ram_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM, never reset, plus an injection port for stray responses.
    logic [31:0] mem [4][32];
    logic        rsp_valid_q;
    logic [1:0]  rsp_layer_q;
    logic [4:0]  rsp_addr_q;
    logic [31:0] rsp_data_q;
    logic        inj_valid;
    logic [1:0]  inj_layer;
    logic [4:0]  inj_addr;
    logic [31:0] inj_data;

    initial begin
        rsp_valid_q = 1'b0;
        rsp_layer_q = '0;
        rsp_addr_q  = '0;
        rsp_data_q  = '0;
    end

    always @(posedge clk) begin
        if (o_ram_enable && !o_ram_rw_select) mem[o_ram_layer][o_ram_addr] <= o_ram_data;
        rsp_valid_q <= o_ram_enable && o_ram_rw_select;
        rsp_layer_q <= o_ram_layer;
        rsp_addr_q  <= o_ram_addr;
        rsp_data_q  <= mem[o_ram_layer][o_ram_addr];
    end

    assign i_ram_valid = inj_valid | rsp_valid_q;
    assign i_ram_layer = inj_valid ? inj_layer : rsp_layer_q;
    assign i_ram_addr  = inj_valid ? inj_addr  : rsp_addr_q;
    assign i_ram_data  = inj_valid ? inj_data  : rsp_data_q;

    int checks;
    int failures;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        wr_start;
        logic [1:0]  wr_layer;
        logic        wr_valid;
        logic [31:0] wr_data;
        logic        rd_start;
        logic [1:0]  rd_layer;
        logic        busy;
        logic        en;
        logic        rw;
        logic [1:0]  ram_layer;
        logic [4:0]  ram_addr;
        logic [31:0] ram_data;
        logic        wr_done;
        logic        rd_valid;
        logic [4:0]  rd_addr;
        logic [31:0] rd_data;
        logic        rd_last;
    } vec_t;

    localparam int NumVec = 14;
    vec_t vecs [NumVec];

    // Drive one row, let one edge pass, compare the registered outputs.
    task automatic apply_row(input vec_t v, input int idx);
        string tag;
        i_wr_start = v.wr_start;
        i_wr_layer = v.wr_layer;
        i_wr_valid = v.wr_valid;
        i_wr_data  = v.wr_data;
        i_rd_start = v.rd_start;
        i_rd_layer = v.rd_layer;
        @(posedge clk);
        #1;
        tag = $sformatf("row%0d", idx);
        check({tag, ".busy"},     32'(o_busy),       32'(v.busy));
        check({tag, ".en"},       32'(o_ram_enable), 32'(v.en));
        check({tag, ".wr_done"},  32'(o_wr_done),    32'(v.wr_done));
        check({tag, ".rd_valid"}, 32'(o_rd_valid),   32'(v.rd_valid));
        if (v.en) begin
            check({tag, ".rw"},    32'(o_ram_rw_select), 32'(v.rw));
            check({tag, ".layer"}, 32'(o_ram_layer),     32'(v.ram_layer));
            check({tag, ".addr"},  32'(o_ram_addr),      32'(v.ram_addr));
            if (!v.rw) check({tag, ".wdata"}, o_ram_data, v.ram_data);
        end
        if (v.rd_valid) begin
            check({tag, ".rd_addr"}, 32'(o_rd_addr), 32'(v.rd_addr));
            check({tag, ".rd_data"}, o_rd_data,      v.rd_data);
        end
        check({tag, ".rd_last"}, 32'(o_rd_last), 32'(v.rd_last));
        check({tag, ".rd_done"}, 32'(o_rd_done), 32'(v.rd_last));
    endtask

    initial begin
        int done_cnt;
        int got;
        checks     = 0;
        failures   = 0;
        rst        = 1'b1;
        i_wr_start = 1'b0;
        i_wr_layer = '0;
        i_wr_valid = 1'b0;
        i_wr_data  = '0;
        i_rd_start = 1'b0;
        i_rd_layer = '0;
        inj_valid  = 1'b0;
        inj_layer  = '0;
        inj_addr   = '0;
        inj_data   = '0;

        // Fields: wr_start wr_layer wr_valid wr_data rd_start rd_layer |
        //         busy en rw ram_layer ram_addr ram_data wr_done rd_valid rd_addr rd_data rd_last
        // Write layer 0: 0x11, 0x22.
        vecs[0]  = '{1, 0, 0, 0,     0, 0, 1, 0, 0, 0, 0, 0,     0, 0, 0, 0,     0};
        vecs[1]  = '{0, 0, 1, 'h11,  0, 0, 1, 1, 0, 0, 0, 'h11,  0, 0, 0, 0,     0};
        vecs[2]  = '{0, 0, 1, 'h22,  0, 0, 0, 1, 0, 0, 1, 'h22,  1, 0, 0, 0,     0};
        vecs[3]  = '{0, 0, 0, 0,     0, 0, 0, 0, 0, 0, 0, 0,     0, 0, 0, 0,     0};
        // Read layer 0 back: requests cycles 1-2, data cycles 3-4.
        vecs[4]  = '{0, 0, 0, 0,     1, 0, 1, 1, 1, 0, 0, 0,     0, 0, 0, 0,     0};
        vecs[5]  = '{0, 0, 0, 0,     0, 0, 1, 1, 1, 0, 1, 0,     0, 0, 0, 0,     0};
        vecs[6]  = '{0, 0, 0, 0,     0, 0, 1, 0, 0, 0, 0, 0,     0, 1, 0, 'h11,  0};
        vecs[7]  = '{0, 0, 0, 0,     0, 0, 0, 0, 0, 0, 0, 0,     0, 1, 1, 'h22,  1};
        vecs[8]  = '{0, 0, 0, 0,     0, 0, 0, 0, 0, 0, 0, 0,     0, 0, 0, 0,     0};
        // Both starts together: write wins; read start during WRITE ignored;
        // wr_valid in IDLE ignored.
        vecs[9]  = '{1, 0, 0, 0,     1, 3, 1, 0, 0, 0, 0, 0,     0, 0, 0, 0,     0};
        vecs[10] = '{0, 0, 1, 'hAA,  1, 3, 1, 1, 0, 0, 0, 'hAA,  0, 0, 0, 0,     0};
        vecs[11] = '{0, 0, 1, 'hBB,  0, 0, 0, 1, 0, 0, 1, 'hBB,  1, 0, 0, 0,     0};
        vecs[12] = '{0, 0, 1, 'hCC,  0, 0, 0, 0, 0, 0, 0, 0,     0, 0, 0, 0,     0};
        vecs[13] = '{0, 0, 0, 0,     0, 0, 0, 0, 0, 0, 0, 0,     0, 0, 0, 0,     0};

        // Reset state.
        #2;
        check("reset.busy",     32'(o_busy),       32'd0);
        check("reset.en",       32'(o_ram_enable), 32'd0);
        check("reset.rd_valid", 32'(o_rd_valid),   32'd0);
        check("reset.wr_done",  32'(o_wr_done),    32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < NumVec; i++) apply_row(vecs[i], i);

        // Layer 1: 32 writes with a bubble every other cycle.
        i_wr_start = 1'b1;
        i_wr_layer = 2'd1;
        @(posedge clk);
        #1;
        i_wr_start = 1'b0;
        done_cnt   = 0;
        for (int i = 0; i < 64; i++) begin
            i_wr_valid = (i % 2 == 0);
            i_wr_data  = 32'(i / 2);
            @(posedge clk);
            #1;
            check($sformatf("l1wr%0d.en", i), 32'(o_ram_enable), 32'(i % 2 == 0));
            if (i % 2 == 0) begin
                check($sformatf("l1wr%0d.addr", i),  32'(o_ram_addr),      32'(i / 2));
                check($sformatf("l1wr%0d.data", i),  o_ram_data,           32'(i / 2));
                check($sformatf("l1wr%0d.layer", i), 32'(o_ram_layer),     32'd1);
                check($sformatf("l1wr%0d.rw", i),    32'(o_ram_rw_select), 32'd0);
            end
            check($sformatf("l1wr%0d.done", i), 32'(o_wr_done), 32'(i == 62));
            if (o_wr_done) done_cnt++;
        end
        i_wr_valid = 1'b0;
        check("l1wr.done_count", 32'(done_cnt), 32'd1);
        check("l1wr.busy_after", 32'(o_busy),   32'd0);

        // Layer 3: preload 0x30..0x32.
        i_wr_start = 1'b1;
        i_wr_layer = 2'd3;
        @(posedge clk);
        #1;
        i_wr_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            i_wr_valid = 1'b1;
            i_wr_data  = 32'h30 + 32'(i);
            @(posedge clk);
            #1;
            check($sformatf("l3wr%0d.addr", i), 32'(o_ram_addr), 32'(i));
        end
        i_wr_valid = 1'b0;
        check("l3wr.done", 32'(o_wr_done), 32'd1);
        @(posedge clk);
        #1;

        // Read layer 3 with a stray layer-2 response for the last address.
        i_rd_start = 1'b1;
        i_rd_layer = 2'd3;
        @(posedge clk);
        #1;
        i_rd_start = 1'b0;
        inj_valid  = 1'b1;
        inj_layer  = 2'd2;
        inj_addr   = 5'd2;
        inj_data   = 32'hDEAD;
        got        = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            inj_valid = 1'b0;
            if (o_rd_valid) begin
                check($sformatf("l3rd%0d.addr", got), 32'(o_rd_addr), 32'(got));
                check($sformatf("l3rd%0d.data", got), o_rd_data,      32'h30 + 32'(got));
                check($sformatf("l3rd%0d.last", got), 32'(o_rd_last), 32'(got == 2));
                got++;
            end
        end
        check("l3rd.count", 32'(got), 32'd3);

        // Reset in the middle of a layer-1 read, at request address 5.
        i_rd_start = 1'b1;
        i_rd_layer = 2'd1;
        @(posedge clk);
        #1;
        i_rd_start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("midrst.pre_addr", 32'(o_ram_addr), 32'd5);
        check("midrst.pre_busy", 32'(o_busy),     32'd1);
        rst = 1'b1;
        #1;
        check("midrst.busy",     32'(o_busy),       32'd0);
        check("midrst.en",       32'(o_ram_enable), 32'd0);
        check("midrst.addr",     32'(o_ram_addr),   32'd0);
        check("midrst.rd_valid", 32'(o_rd_valid),   32'd0);
        check("midrst.rd_addr",  32'(o_rd_addr),    32'd0);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("midrst.late%0d.rd_valid", i), 32'(o_rd_valid), 32'd0);
            check($sformatf("midrst.late%0d.busy", i),     32'(o_busy),     32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/layer_data_ram_controller.md
Name: layer_data_ram_controller

Overview:
- Initiator for the layer-data block RAM (`block_ram_data`-style port: enable, rw_select, layer, addr, data; returns valid/layer/addr/data).
- Write side: accepts a stream of node values from a layer compute stage and writes them to sequential RAM addresses of a selected layer.
- Read side: on request, sweeps all nodes of a selected layer and forwards the returned data as a stream with a last flag.
- Sits between the neuron datapath and the data RAM; serialises all RAM access.

Parameters:
- DATA_WIDTH, 32, node value width.
- LAYER_WIDTH, 2, layer select width.
- NUMBER_OF_INPUT_NODE, 2, node count of layer 0.
- NUMBER_OF_HIDDEN_NODE_LAYER_1, 32, node count of layer 1; must be the largest layer.
- NUMBER_OF_HIDDEN_NODE_LAYER_2, 32, node count of layer 2.
- NUMBER_OF_OUTPUT_NODE, 3, node count of layer 3.
- ADDR_WIDTH (localparam), $clog2(NUMBER_OF_HIDDEN_NODE_LAYER_1), address width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_wr_start  in  1  one-cycle pulse; starts a layer write.
- i_wr_layer  in  LAYER_WIDTH  target layer, sampled with i_wr_start.
- i_wr_valid  in  1  write data valid.
- i_wr_data  in  DATA_WIDTH  node value.
- i_rd_start  in  1  one-cycle pulse; starts a layer read.
- i_rd_layer  in  LAYER_WIDTH  source layer, sampled with i_rd_start.
- o_busy  out  1  high whenever state is not IDLE.
- o_wr_done  out  1  one-cycle pulse after the last write is issued.
- o_rd_valid  out  1  read data valid.
- o_rd_addr  out  ADDR_WIDTH  node index of o_rd_data.
- o_rd_data  out  DATA_WIDTH  node value.
- o_rd_last  out  1  high with the final node of the read.
- o_rd_done  out  1  one-cycle pulse, same cycle as o_rd_last.
- o_ram_enable  out  1  RAM request.
- o_ram_rw_select  out  1  1 = read, 0 = write.
- o_ram_layer  out  LAYER_WIDTH  RAM layer select.
- o_ram_addr  out  ADDR_WIDTH  RAM address.
- o_ram_data  out  DATA_WIDTH  RAM write data.
- i_ram_valid  in  1  RAM read response valid (1-cycle RAM latency).
- i_ram_layer  in  LAYER_WIDTH  response layer.
- i_ram_addr  in  ADDR_WIDTH  response address.
- i_ram_data  in  DATA_WIDTH  response data.

Behaviour:
- All outputs are registered. On reset every output is 0, the state is IDLE, and the counters are 0. Reset takes effect immediately, mid-operation included; RAM responses arriving afterwards are dropped.
- Node count N(layer) is 00→INPUT, 01→H1, 10→H2, 11→OUT. The FSM has four states: IDLE, WRITE, READ_ISSUE, READ_WAIT.
- IDLE:
  - i_wr_start → WRITE; latch the layer and clear the write counter.
  - Otherwise i_rd_start → READ_ISSUE; latch the layer and clear the issue counter.
  - If both pulse in the same cycle, the write wins and the read is dropped.
  - Start pulses are ignored in any non-IDLE state.
- WRITE:
  - On each cycle with i_wr_valid, the next cycle drives o_ram_enable=1, rw=0, the latched layer, addr=counter and data; the counter then increments.
  - Gaps in i_wr_valid produce o_ram_enable=0.
  - When write N-1 is issued, o_wr_done pulses in the same cycle and the state returns to IDLE.
  - i_wr_valid in any other state is ignored.
- READ_ISSUE:
  - Issues reads on consecutive cycles: enable=1, rw=1, addr 0..N-1.
  - After addr N-1 is issued → READ_WAIT.
- READ_WAIT:
  - o_ram_enable=0. Waits for the response with i_ram_addr==N-1.
- Response forwarding (READ_ISSUE/READ_WAIT only):
  - A response is accepted when i_ram_valid=1 and i_ram_layer equals the latched layer.
  - Its addr/data are registered to o_rd_valid/o_rd_addr/o_rd_data one cycle later.
  - The response for N-1 also sets o_rd_last=1 and o_rd_done=1; the state returns to IDLE that cycle.
  - Mismatched or out-of-state responses are dropped.
- Latency:
  - i_rd_start at cycle 0 → addr 0 request at cycle 1 → RAM valid at cycle 2 → o_rd_valid at cycle 3.
  - Streaming is one node per cycle with no bubbles; N nodes complete at cycle N+2.
- Addresses never wrap: the counters stop at N-1. No backpressure on the read stream; the consumer must accept one node per cycle.

Test Plan:
- Reset, then write layer 00 with data 0x11, 0x22 → RAM writes at addr 0, 1 with rw=0, layer=00; o_wr_done pulses with the second write.
- Read layer 00 with a RAM model preloaded → o_rd_valid at cycles 3–4, addr 0, 1, data 0x11, 0x22; o_rd_last and o_rd_done at addr 1.
- Write layer 01 with i_wr_valid toggling every other cycle, 32 values 0..31 → 32 writes, addr 0..31 in order, enable=0 on gap cycles, o_wr_done once.
- i_wr_start and i_rd_start both pulse in IDLE → only the write executes. i_rd_start during WRITE is ignored and no read is issued.
- Read layer 11 while injecting a stray response with layer 10 → the stray is dropped; exactly 3 outputs, addr 0..2.
- Assert rst during READ_ISSUE of layer 01 at addr 5 → outputs are 0 immediately and o_busy=0; late RAM responses produce no o_rd_valid.
